// File: rtl/hazard_interlock.sv
// Issue-side interlock: per-register result-latency counters, EXT unit occupancy,
// and the combinational stall/bubble decision for the instruction in decode.
module hazard_interlock #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned LD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rp1,
    input  logic [4:0]  issue_rp2,
    input  logic        issue_use1,
    input  logic        issue_use2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_wr,
    input  logic [1:0]  issue_kind,
    input  logic        flush,
    output logic        stall,
    output logic        bubble,
    output logic        ext_busy,
    output logic [31:0] pending,
    output logic [15:0] stall_count
);

    localparam int unsigned MAX_LAT = (MUL_LAT > LD_LAT) ? MUL_LAT : LD_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_EXT  = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    cnt_t  cnt [32];
    cnt_t  ext_cnt;
    kind_e kind;
    cnt_t  wr_lat;
    logic  raw;
    logic  waw;
    logic  str;
    logic  accept;
    logic  is_ext;

    assign kind   = kind_e'(issue_kind);
    assign is_ext = (kind == KIND_EXT);

    always_comb begin
        raw = (issue_use1 && (issue_rp1 != 5'd0) && (cnt[issue_rp1] != '0)) ||
              (issue_use2 && (issue_rp2 != 5'd0) && (cnt[issue_rp2] != '0));
        waw = issue_wr && (issue_rd != 5'd0) && (cnt[issue_rd] != '0);
        str = is_ext && (ext_cnt != '0);
    end

    assign stall  = issue_valid && !flush && (raw || waw || str);
    assign bubble = stall;
    assign accept = issue_valid && !flush && !stall;

    // Reserved kind encoding behaves as a plain ALU op.
    always_comb begin
        wr_lat = '0;
        case (kind)
            KIND_LOAD: wr_lat = cnt_t'(LD_LAT);
            KIND_EXT:  wr_lat = cnt_t'(MUL_LAT);
            default:   wr_lat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int unsigned r = 1; r < 32; r++) begin
                if (accept && issue_wr && (issue_rd == 5'(r))) begin
                    cnt[r] <= wr_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_cnt <= '0;
        end else if (accept && is_ext) begin
            ext_cnt <= cnt_t'(MUL_LAT);
        end else if (ext_cnt != '0) begin
            ext_cnt <= ext_cnt - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign ext_busy = (ext_cnt != '0);

    always_comb begin
        pending = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_interlock.sv
// Directed bench for hazard_interlock with default latencies (MUL_LAT=3, LD_LAT=1).
module tb_hazard_interlock;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rp1 = '0;
    logic [4:0]  issue_rp2 = '0;
    logic        issue_use1 = 1'b0;
    logic        issue_use2 = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_wr = 1'b0;
    logic [1:0]  issue_kind = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        bubble;
    logic        ext_busy;
    logic [31:0] pending;
    logic [15:0] stall_count;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_interlock #(.MUL_LAT(3), .LD_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rp1   (issue_rp1),
        .issue_rp2   (issue_rp2),
        .issue_use1  (issue_use1),
        .issue_use2  (issue_use2),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .issue_kind  (issue_kind),
        .flush       (flush),
        .stall       (stall),
        .bubble      (bubble),
        .ext_busy    (ext_busy),
        .pending     (pending),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rp1, input logic u1,
                         input logic [4:0] rp2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic [1:0] kind, input logic fl);
        issue_valid = v;  issue_rp1 = rp1; issue_use1 = u1;
        issue_rp2 = rp2;  issue_use2 = u2; issue_rd = rd;
        issue_wr = wr;    issue_kind = kind; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", pending); end
        n_cmp++; if (ext_busy !== 1'b0) begin n_fail++; $display("FAIL rst_ext_busy: got %b want 0", ext_busy); end
        n_cmp++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL rst_stall_count: got %h want 0", stall_count); end
        n_cmp++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b/%b want 0/0", stall, bubble); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 2'd1, 0); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_issue: stall=%b want 0", stall); end
        @(negedge clk); drive(1, 5, 1, 1, 1, 6, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_fail++; $display("FAIL ld_use_stall: stall/bubble=%b/%b want 1/1", stall, bubble); end
        n_cmp++; if (pending !== 32'h0000_0020) begin n_fail++; $display("FAIL ld_pending: got %h want 00000020", pending); end
        @(negedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_use_accept: stall=%b want 0", stall); end
        n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL ld_pending_clear: got %h want 0", pending); end
        n_cmp++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL ld_stall_count: got %0d want 1", stall_count); end
        @(negedge clk); idle(); #1;
        n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL ld_alu_pending: got %h want 0", pending); end
        n_cmp++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL ld_stall_count_hold: got %0d want 1", stall_count); end
    endtask

    task automatic test_ext_use();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 7, 1, 2'd2, 0); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ext_issue: stall=%b want 0", stall); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 7, 1, 2, 1, 8, 1, 2'd0, 0); #1;
            n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ext_use_stall[%0d]: stall=%b want 1", i, stall); end
            n_cmp++; if (ext_busy !== 1'b1) begin n_fail++; $display("FAIL ext_busy[%0d]: got %b want 1", i, ext_busy); end
            n_cmp++; if (pending !== 32'h0000_0080) begin n_fail++; $display("FAIL ext_pending[%0d]: got %h want 00000080", i, pending); end
        end
        @(negedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ext_use_accept: stall=%b want 0", stall); end
        n_cmp++; if (ext_busy !== 1'b0) begin n_fail++; $display("FAIL ext_busy_drop: got %b want 0", ext_busy); end
        n_cmp++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL ext_stall_count: got %0d want 3", stall_count); end
    endtask

    task automatic test_ext_struct();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 3, 1, 2'd2, 0); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 0, 0, 0, 0, 4, 1, 2'd2, 0); #1;
            n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL str_stall[%0d]: stall=%b want 1", i, stall); end
            n_cmp++; if (pending !== 32'h0000_0008) begin n_fail++; $display("FAIL str_pending[%0d]: got %h want 00000008", i, pending); end
        end
        @(negedge clk); #1;
        n_cmp++; if (stall !== 1'b0 || ext_busy !== 1'b0) begin n_fail++; $display("FAIL str_accept: stall/ext_busy=%b/%b want 0/0", stall, ext_busy); end
        @(negedge clk); idle(); #1;
        n_cmp++; if (ext_busy !== 1'b1) begin n_fail++; $display("FAIL str_second_busy: got %b want 1", ext_busy); end
        n_cmp++; if (pending !== 32'h0000_0010) begin n_fail++; $display("FAIL str_second_pending: got %h want 00000010", pending); end
        n_cmp++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL str_stall_count: got %0d want 3", stall_count); end
    endtask

    task automatic test_waw_r0();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 9, 1, 2'd2, 0); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 0, 0, 0, 0, 9, 1, 2'd0, 0); #1;
            n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall[%0d]: stall=%b want 1", i, stall); end
        end
        @(negedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_accept: stall=%b want 0", stall); end
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1, 2'd1, 0); #1;
        n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL waw_alu_pending: got %h want 0", pending); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_load_stall: stall=%b want 0", stall); end
        @(negedge clk); drive(1, 0, 1, 0, 1, 10, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_use_stall: stall=%b want 0", stall); end
        n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL r0_pending: got %h want 0", pending); end
        n_cmp++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL waw_stall_count: got %0d want 3", stall_count); end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 2'd1, 1); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_issue_stall: stall=%b want 0", stall); end
        @(negedge clk); drive(1, 5, 1, 0, 0, 6, 1, 2'd0, 0); #1;
        n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL flush_pending: got %h want 0", pending); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_consumer: stall=%b want 0", stall); end
        // Hazard present but masked by flush; the counter keeps draining.
        @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 2'd1, 0); #1;
        @(negedge clk); drive(1, 5, 1, 0, 0, 6, 1, 2'd0, 1); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_masks_raw: stall=%b want 0", stall); end
        n_cmp++; if (pending !== 32'h0000_0020) begin n_fail++; $display("FAIL flush_inflight: got %h want 00000020", pending); end
        @(negedge clk); drive(1, 5, 1, 0, 0, 6, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL flush_drain: stall=%b pending=%h want 0/0", stall, pending); end
        n_cmp++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL flush_stall_count: got %0d want 0", stall_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 7, 1, 2'd2, 0); #1;
        @(negedge clk); drive(1, 7, 1, 0, 0, 8, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rm_pre_stall: stall=%b want 1", stall); end
        @(negedge clk); idle(); rst_n = 1'b0; #1;
        n_cmp++; if (pending !== 32'h0 || ext_busy !== 1'b0) begin n_fail++; $display("FAIL rm_clear: pending=%h ext_busy=%b want 0/0", pending, ext_busy); end
        n_cmp++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rm_stall_count: got %0d want 0", stall_count); end
        @(negedge clk); rst_n = 1'b1; drive(1, 7, 1, 0, 0, 8, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_post_consumer: stall=%b want 0", stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 11, 1, 2'd0, 0); #1;
        @(negedge clk); drive(1, 11, 1, 11, 1, 14, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_alu: stall=%b want 0", stall); end
        @(negedge clk); drive(1, 0, 0, 0, 0, 13, 1, 2'd3, 0); #1;
        @(negedge clk); drive(1, 0, 0, 13, 1, 13, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL b2b_kind3: stall=%b pending=%h want 0/0", stall, pending); end
        @(negedge clk); drive(1, 0, 0, 0, 0, 12, 1, 2'd1, 0); #1;
        @(negedge clk); drive(1, 12, 1, 0, 0, 12, 1, 2'd0, 0); #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_raw_waw: stall=%b want 1", stall); end
        @(negedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_resolve: stall=%b want 0", stall); end
        @(negedge clk); idle(); #1;
        n_cmp++; if (pending !== 32'h0 || stall_count !== 16'd1) begin n_fail++; $display("FAIL b2b_final: pending=%h count=%0d want 0/1", pending, stall_count); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_ext_use();
        test_ext_struct();
        test_waw_r0();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_interlock.md
# hazard_interlock

Issue-side interlock for the SimpleRISC pipeline: it tracks destination registers whose results are still in flight and cannot yet be forwarded. It holds an instruction in decode until every source it reads can be supplied by the operand bypass network at ALU entry. It sits between decode and the ALU stage, drives the stall/bubble controls for fetch, decode and ALU, and owns the occupancy of the single non-pipelined extended (EXT) unit.

## Interface
- `MUL_LAT`, default 3: EXT result latency, in cycles, beyond an ALU op (≥1).
- `LD_LAT`, default 1: load result latency, in cycles, beyond an ALU op (≥1).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `issue_valid` in 1: decode holds a valid instruction.
- `issue_rp1`, `issue_rp2` in 5 each: source register numbers.
- `issue_use1`, `issue_use2` in 1 each: the matching source is actually read.
- `issue_rd` in 5: destination register.
- `issue_wr` in 1: instruction writes `issue_rd`.
- `issue_kind` in 2: 0 = ALU, 1 = LOAD, 2 = EXT; 3 is treated as ALU.
- `flush` in 1: branch taken; the decode instruction is killed this cycle.
- `stall` out 1: hold PC and the IF/ID register.
- `bubble` out 1: inject a NOP into ID/EX.
- `ext_busy` out 1: EXT unit occupied.
- `pending` out 32: bit r is set when cnt[r] ≠ 0; bit 0 is always 0.
- `stall_count` out 16: saturating count of stalled cycles.

## Operation
- State:
  - cnt[1..31], each clog2(max(MUL_LAT, LD_LAT)+1) bits wide.
  - ext_cnt, same width.
  - stall_count.
- Hazard terms (combinational):
  - raw = (use1 & rp1 ≠ 0 & cnt[rp1] ≠ 0) | (use2 & rp2 ≠ 0 & cnt[rp2] ≠ 0)
  - waw = wr & rd ≠ 0 & cnt[rd] ≠ 0
  - str = (kind == EXT) & ext_cnt ≠ 0
- stall = issue_valid & ~flush & (raw | waw | str). bubble = stall.
- An instruction is accepted when issue_valid & ~flush & ~stall.
- Per-cycle update of each cnt[r]:
  - If the accepted instruction has wr, rd == r, r ≠ 0: load LD_LAT for LOAD, MUL_LAT for EXT, 0 for ALU.
  - Otherwise, if cnt[r] ≠ 0: decrement.
  - A load takes priority over a decrement on the same register.
- ext_cnt loads MUL_LAT when an EXT instruction is accepted, whether or not it writes a register; otherwise it decrements toward 0. ext_busy = (ext_cnt ≠ 0).
- A flushed instruction never updates state. In-flight counters keep counting through a flush, because older instructions still complete.
- stall_count increments on every cycle with stall = 1 and saturates at 0xFFFF.
- Register 0 is never pending. Reads and writes of r0 never cause a stall.

## Timing
- stall, bubble and the hazard terms are combinational from inputs and current state. They are valid in the same cycle as the issue_* inputs.
- pending, ext_busy and stall_count are registered outputs.
- Reset values: all cnt = 0, ext_cnt = 0, pending = 0, ext_busy = 0, stall_count = 0. stall and bubble read 0 while there are no issue inputs.
- Asserting rst_n mid-operation clears all in-flight tracking immediately. The next issue after reset never stalls on pre-reset producers.
- Back-to-back consumer delay after its producer is accepted:
  - ALU: 0 stall cycles.
  - LOAD: LD_LAT stall cycles.
  - EXT: MUL_LAT stall cycles.
- The consumer is accepted in the first cycle in which the counter reads 0. Its value then comes from the bypass network's WB/DM/EXT taps.
- A producer and a consumer of the same register in consecutive cycles, with the consumer's own write also targeting that register, stall on raw before waw. Both conditions resolve in the same cycle.

## Test plan
- LOAD r5, then ADD r6 ← r5, r1 next cycle (LD_LAT = 1) -> stall = 1 for exactly 1 cycle, then ADD accepted; pending[5] high for 1 cycle; stall_count = 1.
- EXT r7, then SUB r8 ← r7, r2 (MUL_LAT = 3) -> 3 stall cycles, accepted on the 4th; ext_busy high for 3 cycles.
- EXT r3 then EXT r4 back-to-back (no data dependence) -> structural stall for 3 cycles; second EXT accepted when ext_busy drops.
- EXT r9, then ALU write to r9 next cycle -> waw stall for 3 cycles. Separately, LOAD r0 then ADD using r0 -> no stall, pending = 0.
- LOAD r5 with flush = 1 in the same cycle -> no state change, pending[5] = 0, following consumer of r5 not stalled.
- EXT r7 accepted, rst_n low for 1 cycle in the next cycle -> pending, ext_busy and stall_count all 0. A consumer of r7 issued after reset is accepted immediately.
